// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl -- multi-cycle multiply/divide sequencer for the HI/LO pair.
//
// Takes MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX. It holds the front of the pipeline
// while it iterates, then pulses done for one cycle with a registered 64-bit {HI, LO}
// result and the register-file write-select code.
//
// Ports
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   start        EX request valid (held high while stalled)
//   op[2:0]      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x ignored
//   src_a[31:0]  rs operand (dividend / multiplicand / move data)
//   src_b[31:0]  rt operand (divisor / multiplier)
//   flush        cancel any in-flight operation (highest priority)
//   stall        hold IF..EX
//   done         one-cycle completion pulse
//   result[63:0] {HI, LO}; zero when done is low
//   hilo_flag    111 mul/div, 110 MTHI, 101 MTLO, 000 when done is low
//   div_by_zero  pulses with done for DIV/DIVU with src_b == 0
module hilo_mdu_ctrl #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [63:0] result,
  output logic [2:0]  hilo_flag,
  output logic        div_by_zero
);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

  localparam logic [2:0] FLAG_BOTH = 3'b111;
  localparam logic [2:0] FLAG_HI   = 3'b110;
  localparam logic [2:0] FLAG_LO   = 3'b101;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [63:0] result_q, result_d;
  logic [2:0]  flag_q, flag_d;
  logic        dbz_q, dbz_d;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? neg32(v) : v;
  endfunction

  logic        op_valid;
  logic [31:0] mul_a, mul_b;
  logic        mul_signed;
  logic [63:0] ext_a, ext_b, prod;

  logic        div_signed;
  logic [31:0] dvs;
  logic [32:0] shifted, trial;
  logic        fits;
  logic [31:0] step_rem, step_quo, rem_fix, quo_fix;

  assign op_valid = (op[2:1] != 2'b11);

  // With MUL_LAT == 1 the product is formed straight from the EX operands in IDLE.
  always_comb begin
    mul_a      = (state_q == IDLE) ? src_a : a_q;
    mul_b      = (state_q == IDLE) ? src_b : b_q;
    mul_signed = (state_q == IDLE) ? (op == OP_MULT) : (op_q == OP_MULT);
    ext_a      = mul_signed ? {{32{mul_a[31]}}, mul_a} : {32'h0, mul_a};
    ext_b      = mul_signed ? {{32{mul_b[31]}}, mul_b} : {32'h0, mul_b};
    prod       = ext_a * ext_b;
  end

  // One restoring step on magnitudes: {rem, quo} shifts left, the dividend bits
  // leave quo from the top while quotient bits enter at the bottom.
  always_comb begin
    div_signed = (op_q == OP_DIV);
    dvs        = mag32(b_q, div_signed);
    shifted    = {rem_q, quo_q[31]};
    trial      = shifted - {1'b0, dvs};
    fits       = (shifted >= {1'b0, dvs});
    step_rem   = fits ? trial[31:0] : shifted[31:0];
    step_quo   = {quo_q[30:0], fits};
    quo_fix    = (div_signed && (a_q[31] ^ b_q[31])) ? neg32(step_quo) : step_quo;
    rem_fix    = (div_signed && a_q[31]) ? neg32(step_rem) : step_rem;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = '0;
    flag_d   = '0;
    dbz_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && op_valid && !flush) begin
          op_d  = op_e'(op);
          a_d   = src_a;
          b_d   = src_b;
          rem_d = '0;
          quo_d = mag32(src_a, op == OP_DIV);
          if (op[2]) begin
            // Moves have one-cycle latency, so they load the completion registers
            // on the accepting edge instead of passing through a separate state.
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = {32'h0, src_a};
            flag_d   = op[0] ? FLAG_LO : FLAG_HI;
          end else if (op[1]) begin
            state_d = DIV;
            cnt_d   = 5'd31;
          end else if (MUL_LAT == 1) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = prod;
            flag_d   = FLAG_BOTH;
          end else begin
            state_d = MUL;
            cnt_d   = 5'(MUL_LAT - 2);
          end
        end
      end
      MUL: begin
        if (cnt_q == '0) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = prod;
          flag_d   = FLAG_BOTH;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          flag_d  = FLAG_BOTH;
          if (b_q == '0) begin
            result_d = {a_q, 32'hFFFF_FFFF};
            dbz_d    = 1'b1;
          end else begin
            result_d = {rem_fix, quo_fix};
          end
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = '0;
      flag_d   = '0;
      dbz_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      op_q     <= OP_MULT;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      flag_q   <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      dbz_q    <= dbz_d;
    end
  end

  // Gated by resetn so every output reads 0 while reset is asserted.
  assign stall = resetn &&
                 (((state_q == IDLE) && start && !op[2]) ||
                  (state_q == MUL) || (state_q == DIV));

  assign done        = done_q;
  assign result      = result_q;
  assign hilo_flag   = flag_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
module tb_hilo_mdu_ctrl;

  localparam int unsigned MUL_LAT = 4;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [63:0] result;
  logic [2:0]  hilo_flag;
  logic        div_by_zero;

  hilo_mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .stall       (stall),
    .done        (done),
    .result      (result),
    .hilo_flag   (hilo_flag),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [2:0]  flag;
    logic        dbz;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   idle_viol = 0;
  exp_t mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.tag, "_result"}, result, mon_e.res);
          check({mon_e.tag, "_flag"}, 64'(hilo_flag), 64'(mon_e.flag));
          check({mon_e.tag, "_dbz"}, 64'(div_by_zero), 64'(mon_e.dbz));
        end
      end else if (result != '0 || hilo_flag != '0 || div_by_zero) begin
        idle_viol++;
      end
    end
  end

  function automatic int exp_lat(input logic [2:0] o);
    return o[2] ? 1 : (o[1] ? 33 : int'(MUL_LAT));
  endfunction

  function automatic int exp_stall(input logic [2:0] o);
    return o[2] ? 0 : (o[1] ? 33 : int'(MUL_LAT));
  endfunction

  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] r, output logic [2:0] f, output logic z);
    int     sa, sb_v, sq, sr;
    longint sp;
    sa   = $signed(a);
    sb_v = $signed(b);
    z    = 1'b0;
    f    = 3'b111;
    r    = '0;
    case (o)
      3'd0: begin
        sp = longint'(sa) * longint'(sb_v);
        r  = sp;
      end
      3'd1: r = {32'h0, a} * {32'h0, b};
      3'd2, 3'd3: begin
        if (b == 32'h0) begin
          r = {a, 32'hFFFF_FFFF};
          z = 1'b1;
        end else if (o == 3'd3) begin
          r = {a % b, a / b};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r = {32'h0, 32'h8000_0000};
        end else begin
          sq = sa / sb_v;
          sr = sa % sb_v;
          r  = {sr, sq};
        end
      end
      3'd4: begin
        r = {32'h0, a};
        f = 3'b110;
      end
      default: begin
        r = {32'h0, a};
        f = 3'b101;
      end
    endcase
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] er, input logic [2:0] ef, input logic ed,
                       input string tag);
    int cyc;
    int stall_cnt;
    int stall_at_done;
    bit seen;
    exp_t e;
    e.res  = er;
    e.flag = ef;
    e.dbz  = ed;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    #1;
    stall_cnt     = stall ? 1 : 0;
    stall_at_done = 0;
    cyc           = 0;
    seen          = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        seen          = 1'b1;
        stall_at_done = stall ? 1 : 0;
      end else begin
        stall_cnt += stall ? 1 : 0;
      end
    end
    start = 1'b0;
    if (!seen) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      void'(sb.pop_back());
    end else begin
      check({tag, "_latency"}, 64'(cyc), 64'(exp_lat(o)));
      check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_stall(o)));
      check({tag, "_stall_at_done"}, 64'(stall_at_done), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    logic [63:0] mr;
    logic [2:0]  mf;
    logic        mz;
    int          bad;

    resetn = 1'b0;
    start  = 1'b0;
    op     = 3'b000;
    src_a  = '0;
    src_b  = '0;
    flush  = 1'b0;

    #3;
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_flag", 64'(hilo_flag), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    do_op(3'b000, 32'hFFFF_FFFF, 32'h2, 64'hFFFF_FFFF_FFFF_FFFE, 3'b111, 1'b0, "mult");
    do_op(3'b001, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE, 3'b111, 1'b0, "multu");
    do_op(3'b010, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD, 3'b111, 1'b0, "div_neg");
    do_op(3'b011, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 3'b111, 1'b0, "divu");
    do_op(3'b011, 32'h1234, 32'h0, 64'h0000_1234_FFFF_FFFF, 3'b111, 1'b1, "divu_zero");
    do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 3'b111, 1'b0, "div_ovf");
    do_op(3'b010, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 3'b111, 1'b0, "div_negb");
    do_op(3'b100, 32'hCAFE_F00D, 32'h0, 64'h0000_0000_CAFE_F00D, 3'b110, 1'b0, "mthi");

    // Reserved op codes are never accepted.
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = 3'b110;
    for (int i = 0; i < 3; i++) begin
      #1 check("op110_stall", 64'(stall), 64'd0);
      @(posedge clk);
      #1;
    end
    op = 3'b111;
    for (int i = 0; i < 3; i++) begin
      #1 check("op111_stall", 64'(stall), 64'd0);
      @(posedge clk);
      #1;
    end
    start = 1'b0;

    // Flush on the tenth DIV cycle, with start still asserted in the flush cycle.
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = 3'b010;
    src_a = 32'd1000;
    src_b = 32'd3;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    check("flush_pre_stall", 64'(stall), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    #1 check("flush_post_stall", 64'(stall), 64'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || stall) bad++;
    end
    check("flush_no_done", 64'(bad), 64'd0);
    do_op(3'b101, 32'h1234, 32'h0, 64'h0000_0000_0000_1234, 3'b101, 1'b0, "mtlo");

    for (int i = 0; i < 14; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 1000));
        2:       rb = -32'($urandom_range(1, 1000));
        default: rb = $urandom;
      endcase
      model(ro, ra, rb, mr, mf, mz);
      do_op(ro, ra, rb, mr, mf, mz, $sformatf("rand%0d_op%0d", i, ro));
    end

    // Reset in the middle of a multiply abandons it.
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = 3'b000;
    src_a = 32'd12345;
    src_b = 32'd678;
    @(posedge clk);
    @(posedge clk);
    #1;
    start  = 1'b0;
    resetn = 1'b0;
    #1;
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_result", result, 64'd0);
    check("midreset_flag", 64'(hilo_flag), 64'd0);
    check("midreset_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done || stall) bad++;
    end
    check("midreset_no_done", 64'(bad), 64'd0);

    check("outputs_zero_when_idle", 64'(idle_viol), 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
